id_stage: RTL
=============

Name: id_stage

Overview:
- RV32I decode / operand-fetch stage. Sits between instruction fetch and execute, and directly drives the read ports of reg_bank.
- Accepts one instruction per handshake, decodes rd, immediate and write-enable, and issues rs1/rs2 to reg_bank.
- Presents operands to execute with a valid/ready handshake.
- Tracks writeback writes so a write landing in the read-issue cycle is never missed.

Parameters:
- XLEN, 32, data/PC width.
- RAW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- if_valid  in  1  fetch holds an instruction.
- if_ready  out  1  stage can accept.
- if_instr  in  32  instruction word.
- if_pc  in  XLEN  PC of if_instr.
- raddr1  out  RAW  rs1 address to reg_bank.
- raddr2  out  RAW  rs2 address to reg_bank.
- dout1  in  XLEN  reg_bank read data 1.
- dout2  in  XLEN  reg_bank read data 2.
- wb_we  in  1  writeback write enable (same net as reg_bank w_enable).
- wb_waddr  in  RAW  writeback address (same net as reg_bank waddr).
- wb_wdata  in  XLEN  writeback data (same net as reg_bank din).
- ex_valid  out  1  operands valid.
- ex_ready  in  1  execute accepts.
- ex_pc  out  XLEN  latched PC.
- ex_instr  out  32  latched instruction.
- ex_rs1_val  out  XLEN  operand 1.
- ex_rs2_val  out  XLEN  operand 2.
- ex_imm  out  XLEN  sign-extended immediate.
- ex_rd  out  RAW  destination register.
- ex_rd_we  out  1  destination is written.
- ex_illegal  out  1  unsupported opcode.

Behaviour:
- reg_bank contract:
  - Read is synchronous: dout reflects raddr sampled at the previous edge.
  - Write commits at the edge; a same-edge read returns the old value.
  - x0 always reads 0.
- FSM states: EMPTY, FULL, REREAD.
- Handshake signals:
  - if_ready = !flush && (EMPTY || (FULL && ex_ready)).
  - ex_valid = FULL.
  - Accept = if_valid && if_ready.
- raddr1/2 (combinational):
  - On accept: if_instr[19:15] and [24:20].
  - Otherwise: held rs1/rs2 of the latched instruction.
  - In EMPTY with no accept: 0.
- Transitions:
  - EMPTY: accept goes to FULL.
  - FULL: ex_ready && !accept goes to EMPTY; ex_ready && accept stays FULL with new instruction; !ex_ready holds.
  - REREAD goes to FULL after exactly one cycle.
- Hazard at edge E:
  - Condition: the stage will be FULL after E, wb_we=1, wb_waddr != 0, and wb_waddr equals rs1 or rs2 of the instruction that is latched after E (new or held).
  - Effect: dout in the following cycle is stale for that operand.
- Decode (registered at accept):
  - Immediate by opcode: I (0010011, 0000011, 1100111), S (0100011), B (1100011), U (0110111, 0010111), J (1101111), else 0.
  - ex_rd_we = opcode not S/B, and rd != 0.
  - ex_illegal = opcode outside RV32I base set (also 0001111, 1110011, 0110011 are legal). Illegal instructions are still passed, with ex_rd_we = 0.
- Flush:
  - State goes to EMPTY; forward flags clear.
  - No accept in the flush cycle; flush beats if_valid.
- Reset (asynchronous):
  - State EMPTY.
  - All ex_* outputs 0, raddr 0, forward registers 0.
  - Takes effect mid-operation immediately; the in-flight instruction is discarded.
- Operand ordering versus older in-flight instructions (not yet written back) is owned by the hazard unit, not this stage.

Optional Feature:
- Macro: ID_WB_FWD_EN.
- Defined:
  - On a hazard, capture wb_wdata into fwd1/fwd2 registers and set fwdN_v.
  - ex_rsN_val = fwdN_v ? fwdN : doutN.
  - fwdN_v clears on accept of a non-matching instruction or on flush; a later matching write overwrites it.
  - No bubble; REREAD is unreachable.
- Undefined:
  - A hazard goes to REREAD instead of FULL. ex_valid is low for one cycle while the held addresses re-read, then FULL.
  - ex_rsN_val = doutN directly.

Decomposition:
- Package rv32_pkg holds:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM);
  - the id_state_e enum (EMPTY, FULL, REREAD);
  - the imm_fmt_e enum (I, S, B, U, J, NONE).
- One sub-module, imm_gen: combinational, instr to imm + format, reused by execute for branch targets.

Test Plan:
- Reset:
  - Stimulus: reset=1 mid-FULL.
  - Required: ex_valid=0 and if_ready=1 immediately; all ex_* equal 0.
- Basic accept:
  - Stimulus: instr 0x00A00093 (addi x1,x0,10) accepted with x0 reading 0.
  - Required: next cycle ex_valid=1, ex_rd=1, ex_imm=10, ex_rs1_val=0, ex_rd_we=1.
- Backpressure:
  - Stimulus: ex_ready=0 for 3 cycles with add x3,x1,x2, x1=10, x2=2.
  - Required: ex_* held stable, if_ready=0, raddr=1/2, ex_rs1_val=10, ex_rs2_val=2.
- Hazard in the accept cycle:
  - Stimulus: accept add x3,x1,x2 while wb writes x1=7 in the same cycle.
  - Required with ID_WB_FWD_EN: ex_valid next cycle, ex_rs1_val=7.
  - Required without it: one ex_valid=0 bubble, then ex_rs1_val=7.
- x0 write:
  - Stimulus: wb_we=1, wb_waddr=0, wb_wdata=10 while the held rs1=0.
  - Required: no hazard, no bubble, ex_rs1_val=0.
- Flush:
  - Stimulus: flush=1 with if_valid=1 while FULL.
  - Required: if_ready=0, next cycle EMPTY with ex_valid=0; fetch instruction not accepted.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I decode definitions.
//   - base opcode constants
//   - id_state_e : decode-stage occupancy states
//   - imm_fmt_e  : immediate encoding formats
//   - is_rv32i_opcode() : true for every RV32I base opcode
package rv32_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    REREAD
  } id_state_e;

  typedef enum logic [2:0] {
    I,
    S,
    B,
    U,
    J,
    NONE
  } imm_fmt_e;

  function automatic logic is_rv32i_opcode(input logic [6:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate extraction.
// Also used by execute to form branch/jump targets.
// Ports:
//   instr : 32-bit instruction word
//   imm   : sign-extended immediate (0 for formats without one)
//   fmt   : immediate format selected by the opcode
module imm_gen
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
);

  logic signed [31:0] imm32;

  always_comb begin
    fmt   = NONE;
    imm32 = '0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt   = I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        fmt   = S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt   = B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt   = U;
        imm32 = {instr[31:12], 12'h000};
      end
      OP_JAL: begin
        fmt   = J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        fmt   = NONE;
        imm32 = '0;
      end
    endcase
  end

  // Sign-extend to XLEN (no-op at XLEN=32).
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode / operand-fetch stage.
// Accepts one instruction per fetch handshake, registers its decode, drives
// the synchronous reg_bank read ports and presents operands to execute.
// A writeback landing on a source register in the read-issue edge makes the
// reg_bank data stale; this is repaired either by a one-cycle re-read bubble
// (default) or by capturing the writeback data (macro ID_WB_FWD_EN).
// Ports:
//   clk, reset            clock, async active-high reset
//   flush                 synchronous flush (beats if_valid)
//   if_valid/if_ready     fetch handshake; if_instr, if_pc payload
//   raddr1/raddr2         reg_bank read addresses (combinational)
//   dout1/dout2           reg_bank read data (valid one cycle after raddr)
//   wb_we/waddr/wdata     writeback port snooped for hazards
//   ex_valid/ex_ready     execute handshake
//   ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rd_we,
//   ex_illegal            operand/decode bundle for execute
// Configuration: `define ID_WB_FWD_EN to forward writeback data instead of
// re-reading.
//
// state  | meaning
// EMPTY  | no instruction held
// FULL   | instruction held, operands valid on ex_*
// REREAD | instruction held, read data stale, re-issuing held addresses
module id_stage
  import rv32_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [RAW-1:0]  raddr1,
  output logic [RAW-1:0]  raddr2,
  input  logic [XLEN-1:0] dout1,
  input  logic [XLEN-1:0] dout2,
  input  logic            wb_we,
  input  logic [RAW-1:0]  wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [31:0]     ex_instr,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [RAW-1:0]  ex_rd,
  output logic            ex_rd_we,
  output logic            ex_illegal
);

  id_state_e state_q, state_d;

  logic            accept;
  logic            will_be_full;
  logic            hit1, hit2, hazard;
  logic [RAW-1:0]  held_rs1, held_rs2;
  logic [XLEN-1:0] imm_new;
  imm_fmt_e        fmt_new;
  logic            legal_new;

  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [31:0]     ex_instr_q, ex_instr_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [RAW-1:0]  ex_rd_q, ex_rd_d;
  logic            ex_rd_we_q, ex_rd_we_d;
  logic            ex_illegal_q, ex_illegal_d;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_instr),
    .imm   (imm_new),
    .fmt   (fmt_new)
  );

  assign legal_new = is_rv32i_opcode(if_instr[6:0]);
  assign held_rs1  = RAW'(ex_instr_q[19:15]);
  assign held_rs2  = RAW'(ex_instr_q[24:20]);

  always_comb begin
    if_ready = !flush && ((state_q == EMPTY) || ((state_q == FULL) && ex_ready));
    accept   = if_valid && if_ready;
  end

  // Read addresses: the incoming instruction on accept, otherwise keep
  // re-reading the held operands so dout tracks committed writes.
  always_comb begin
    raddr1 = '0;
    raddr2 = '0;
    if (!reset) begin
      if (accept) begin
        raddr1 = RAW'(if_instr[19:15]);
        raddr2 = RAW'(if_instr[24:20]);
      end else if (state_q != EMPTY) begin
        raddr1 = held_rs1;
        raddr2 = held_rs2;
      end
    end
  end

  always_comb begin
    will_be_full = 1'b0;
    unique case (state_q)
      EMPTY:   will_be_full = accept;
      FULL:    will_be_full = !ex_ready || accept;
      REREAD:  will_be_full = 1'b1;
      default: will_be_full = 1'b0;
    endcase
    if (flush) will_be_full = 1'b0;

    // raddr at this edge is exactly the rs1/rs2 of the instruction held after it.
    hit1   = wb_we && (wb_waddr != '0) && (wb_waddr == raddr1);
    hit2   = wb_we && (wb_waddr != '0) && (wb_waddr == raddr2);
    hazard = will_be_full && (hit1 || hit2);

`ifdef ID_WB_FWD_EN
    state_d = will_be_full ? FULL : EMPTY;
`else
    if (!will_be_full)  state_d = EMPTY;
    else if (hazard)    state_d = REREAD;
    else                state_d = FULL;
`endif
  end

  always_comb begin
    ex_pc_d      = ex_pc_q;
    ex_instr_d   = ex_instr_q;
    ex_imm_d     = ex_imm_q;
    ex_rd_d      = ex_rd_q;
    ex_rd_we_d   = ex_rd_we_q;
    ex_illegal_d = ex_illegal_q;
    if (accept) begin
      ex_pc_d      = if_pc;
      ex_instr_d   = if_instr;
      ex_imm_d     = imm_new;
      ex_rd_d      = RAW'(if_instr[11:7]);
      ex_illegal_d = !legal_new;
      ex_rd_we_d   = legal_new && (fmt_new != S) && (fmt_new != B) && (if_instr[11:7] != 5'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      ex_pc_q      <= '0;
      ex_instr_q   <= '0;
      ex_imm_q     <= '0;
      ex_rd_q      <= '0;
      ex_rd_we_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ex_pc_q      <= ex_pc_d;
      ex_instr_q   <= ex_instr_d;
      ex_imm_q     <= ex_imm_d;
      ex_rd_q      <= ex_rd_d;
      ex_rd_we_q   <= ex_rd_we_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

`ifdef ID_WB_FWD_EN
  logic [XLEN-1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic            fwd1_v_q, fwd1_v_d, fwd2_v_q, fwd2_v_d;

  // A matching write always wins (also refreshes a held capture); any other
  // accept drops the capture since the fresh read is then correct.
  always_comb begin
    fwd1_d   = fwd1_q;
    fwd2_d   = fwd2_q;
    fwd1_v_d = fwd1_v_q;
    fwd2_v_d = fwd2_v_q;
    if (!will_be_full) begin
      fwd1_v_d = 1'b0;
      fwd2_v_d = 1'b0;
    end else begin
      if (hit1) begin
        fwd1_v_d = 1'b1;
        fwd1_d   = wb_wdata;
      end else if (accept) begin
        fwd1_v_d = 1'b0;
      end
      if (hit2) begin
        fwd2_v_d = 1'b1;
        fwd2_d   = wb_wdata;
      end else if (accept) begin
        fwd2_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd1_q   <= '0;
      fwd2_q   <= '0;
      fwd1_v_q <= 1'b0;
      fwd2_v_q <= 1'b0;
    end else begin
      fwd1_q   <= fwd1_d;
      fwd2_q   <= fwd2_d;
      fwd1_v_q <= fwd1_v_d;
      fwd2_v_q <= fwd2_v_d;
    end
  end

  assign ex_rs1_val = (state_q == FULL) ? (fwd1_v_q ? fwd1_q : dout1) : '0;
  assign ex_rs2_val = (state_q == FULL) ? (fwd2_v_q ? fwd2_q : dout2) : '0;
`else
  logic unused_wb_wdata;
  assign unused_wb_wdata = ^wb_wdata;

  // Gated so the operand bus reads zero whenever ex_valid is low.
  assign ex_rs1_val = (state_q == FULL) ? dout1 : '0;
  assign ex_rs2_val = (state_q == FULL) ? dout2 : '0;
`endif

  assign ex_valid   = (state_q == FULL);
  assign ex_pc      = ex_pc_q;
  assign ex_instr   = ex_instr_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rd      = ex_rd_q;
  assign ex_rd_we   = ex_rd_we_q;
  assign ex_illegal = ex_illegal_q;

endmodule
